// File: rtl/tc_tile_ctrl.sv
// tc_tile_ctrl: top-level sequencer for one tensor-core tile, D = A*B + C.
// Fetches C, A and B over the AXI request port, runs the systolic array
// (plus an accumulate phase for integer types), drains, then writes D back.
//
// axi_out layout (MSB..LSB):
//   BASE[92:61] sel[60:58] issend[57] bits[56:25]
//   burst_num[24:9] burst_size[8:1] request_valid[0]
// base layout: {A[127:96], B[95:64], C[63:32], D[31:0]}
module tc_tile_ctrl #(
    parameter int ACC_CYCLES = 2,
    parameter int BEAT_BITS  = 32,
    parameter int MAX_BURST  = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   dtype,
    input  logic [1:0]   rc,
    input  logic [127:0] base,
    input  logic [31:0]  systolic_time,
    input  logic [31:0]  writeback_time,
    output logic [92:0]  axi_out,
    input  logic         axi_finish,
    output logic         sys_en,
    output logic         acc_en,
    output logic [3:0]   state,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1,
        INT8 = 2'd2,
        INT4 = 2'd3
    } type_t;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_READ_C     = 4'd1,
        ST_LOAD_A     = 4'd2,
        ST_LOAD_B     = 4'd3,
        ST_SYSTOLIC   = 4'd4,
        ST_ACCUMULATE = 4'd5,
        ST_WAIT_WRITE = 4'd6,
        ST_WRITE_BACK = 4'd7,
        ST_FINISH     = 4'd8
    } state_t;

    typedef struct packed {
        logic [31:0] BASE;
        logic [2:0]  sel;
        logic        issend;
        logic [31:0] bits;
        logic [15:0] burst_num;
        logic [7:0]  burst_size;
        logic        request_valid;
    } AXI_out_t;

    localparam logic [31:0] BEAT_U    = 32'(BEAT_BITS);
    localparam logic [31:0] MAX_U     = 32'(MAX_BURST);
    localparam logic [31:0] ACC_LEN   = 32'(ACC_CYCLES);
    localparam logic [31:0] CD_BITS   = 32'd8192;   // 256 elements x 32 bits

    state_t      st_q;
    AXI_out_t    axi_q;
    logic [31:0] cnt_q;
    type_t       dtype_q;
    logic [1:0]  rc_q;
    logic [127:0] base_q;
    logic [31:0] systolic_time_q;
    logic [31:0] writeback_time_q;

    // Phase lengths of zero still spend one cycle in the phase.
    function automatic logic [31:0] at_least_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    // Request fields for one of the four AXI request states; request_valid
    // always starts low so every request begins with its bubble cycle.
    function automatic AXI_out_t req_fields(input state_t req, input logic [1:0] dt,
                                            input logic [1:0] shape, input logic [127:0] b);
        AXI_out_t    f;
        logic [31:0] width;
        logic [31:0] beats;
        // NOTE: every field gets a default up front so no path leaves a value unassigned.
        f     = '0;
        width = 32'd32 >> dt;
        case (req)
            ST_READ_C: begin
                f.sel  = 3'b001;
                f.BASE = b[63:32];
                f.bits = CD_BITS;
            end
            ST_LOAD_A: begin
                f.sel  = 3'b100;
                f.BASE = b[127:96];
                f.bits = (32'd512 >> shape) * width;
            end
            ST_LOAD_B: begin
                f.sel  = 3'b010;
                f.BASE = b[95:64];
                f.bits = (32'd128 << shape) * width;
            end
            ST_WRITE_BACK: begin
                f.sel    = 3'b000;
                f.BASE   = b[31:0];
                f.issend = 1'b1;
                f.bits   = CD_BITS;
            end
            default: ;
        endcase
        beats = f.bits / BEAT_U;
        // Counts are powers of two, so the split into bursts is exact.
        if (beats > MAX_U) begin
            f.burst_size = MAX_U[7:0];
            f.burst_num  = 16'(beats / MAX_U);
        end else begin
            f.burst_size = beats[7:0];
            f.burst_num  = 16'd1;
        end
        return f;
    endfunction

    assign axi_out = axi_q;
    assign state   = st_q;
    assign busy    = (st_q != ST_IDLE);

    // Tile sequencer: state, phase counter, latched config and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q             <= ST_IDLE;
            axi_q            <= '0;
            cnt_q            <= '0;
            dtype_q          <= FP32;
            rc_q             <= '0;
            base_q           <= '0;
            systolic_time_q  <= '0;
            writeback_time_q <= '0;
            sys_en           <= 1'b0;
            acc_en           <= 1'b0;
            done             <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
            cfg_err <= 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (start) begin
                        if (rc == 2'b11) begin
                            cfg_err <= 1'b1;
                        end else begin
                            dtype_q          <= type_t'(dtype);
                            rc_q             <= rc;
                            base_q           <= base;
                            systolic_time_q  <= systolic_time;
                            writeback_time_q <= writeback_time;
                            st_q             <= ST_READ_C;
                            axi_q            <= req_fields(ST_READ_C, dtype, rc, base);
                        end
                    end
                end

                ST_READ_C, ST_LOAD_A, ST_LOAD_B, ST_WRITE_BACK: begin
                    if (!axi_q.request_valid) begin
                        axi_q.request_valid <= 1'b1;
                    end else if (axi_finish) begin
                        case (st_q)
                            ST_READ_C: begin
                                st_q  <= ST_LOAD_A;
                                axi_q <= req_fields(ST_LOAD_A, dtype_q, rc_q, base_q);
                            end
                            ST_LOAD_A: begin
                                st_q  <= ST_LOAD_B;
                                axi_q <= req_fields(ST_LOAD_B, dtype_q, rc_q, base_q);
                            end
                            ST_LOAD_B: begin
                                st_q   <= ST_SYSTOLIC;
                                axi_q  <= '0;
                                sys_en <= 1'b1;
                                cnt_q  <= at_least_one(systolic_time_q);
                            end
                            default: begin
                                st_q  <= ST_FINISH;
                                axi_q <= '0;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_SYSTOLIC: begin
                    if (cnt_q == 32'd1) begin
                        sys_en <= 1'b0;
                        if (dtype_q == INT8 || dtype_q == INT4) begin
                            st_q   <= ST_ACCUMULATE;
                            acc_en <= 1'b1;
                            cnt_q  <= ACC_LEN;
                        end else begin
                            st_q  <= ST_WAIT_WRITE;
                            cnt_q <= at_least_one(writeback_time_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end

                ST_ACCUMULATE: begin
                    if (cnt_q == 32'd1) begin
                        acc_en <= 1'b0;
                        st_q   <= ST_WAIT_WRITE;
                        cnt_q  <= at_least_one(writeback_time_q);
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end

                ST_WAIT_WRITE: begin
                    if (cnt_q == 32'd1) begin
                        st_q  <= ST_WRITE_BACK;
                        axi_q <= req_fields(ST_WRITE_BACK, dtype_q, rc_q, base_q);
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end

                ST_FINISH: begin
                    done <= 1'b0;
                    st_q <= ST_IDLE;
                end

                default: begin
                    st_q   <= ST_IDLE;
                    axi_q  <= '0;
                    sys_en <= 1'b0;
                    acc_en <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_tile_ctrl.sv
// tb_tc_tile_ctrl: directed bench for tc_tile_ctrl with hand-computed
// request fields and phase lengths; outputs are sampled on the falling edge.
module tb_tc_tile_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_READ_C = 4'd1, S_LOAD_A = 4'd2, S_LOAD_B = 4'd3,
                           S_SYSTOLIC = 4'd4, S_ACC = 4'd5, S_WAIT = 4'd6,
                           S_WRITE_BACK = 4'd7, S_FINISH = 4'd8;
    localparam logic [1:0] T_FP32 = 2'd0, T_FP16 = 2'd1, T_INT8 = 2'd2, T_INT4 = 2'd3;

    localparam logic [31:0] A_ADDR = 32'hA000_0000;
    localparam logic [31:0] B_ADDR = 32'hB000_1000;
    localparam logic [31:0] C_ADDR = 32'hC000_2000;
    localparam logic [31:0] D_ADDR = 32'hD000_3000;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   dtype;
    logic [1:0]   rc;
    logic [127:0] base;
    logic [31:0]  systolic_time;
    logic [31:0]  writeback_time;
    logic [92:0]  axi_out;
    logic         axi_finish;
    logic         sys_en;
    logic         acc_en;
    logic [3:0]   state;
    logic         busy;
    logic         done;
    logic         cfg_err;

    logic [31:0] o_base;
    logic [2:0]  o_sel;
    logic        o_issend;
    logic [31:0] o_bits;
    logic [15:0] o_bnum;
    logic [7:0]  o_bsize;
    logic        o_valid;

    assign o_base   = axi_out[92:61];
    assign o_sel    = axi_out[60:58];
    assign o_issend = axi_out[57];
    assign o_bits   = axi_out[56:25];
    assign o_bnum   = axi_out[24:9];
    assign o_bsize  = axi_out[8:1];
    assign o_valid  = axi_out[0];

    int n_checks = 0;
    int n_pass   = 0;

    tc_tile_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dtype          (dtype),
        .rc             (rc),
        .base           (base),
        .systolic_time  (systolic_time),
        .writeback_time (writeback_time),
        .axi_out        (axi_out),
        .axi_finish     (axi_finish),
        .sys_en         (sys_en),
        .acc_en         (acc_en),
        .state          (state),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Called at the falling edge of a request state's entry cycle; returns at
    // the falling edge of the following state's first cycle.
    task automatic serve_req(input string tag, input logic [3:0] exp_st, input logic [2:0] exp_sel,
                             input logic [31:0] exp_base, input logic [31:0] exp_bits,
                             input logic [7:0] exp_bsize, input logic [15:0] exp_bnum,
                             input logic exp_issend);
        check({tag, ".state"},  state,    exp_st);
        check({tag, ".bubble"}, o_valid,  1'b0);
        check({tag, ".sel"},    o_sel,    exp_sel);
        check({tag, ".base"},   o_base,   exp_base);
        check({tag, ".bits"},   o_bits,   exp_bits);
        check({tag, ".bsize"},  o_bsize,  exp_bsize);
        check({tag, ".bnum"},   o_bnum,   exp_bnum);
        check({tag, ".issend"}, o_issend, exp_issend);
        @(negedge clk);
        check({tag, ".valid"}, o_valid, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check({tag, ".held_state"}, state,   exp_st);
        check({tag, ".held_valid"}, o_valid, 1'b1);
        axi_finish = 1'b1;
        @(posedge clk);
        #1 axi_finish = 1'b0;
        @(negedge clk);
        check({tag, ".drop_valid"}, o_valid, 1'b0);
    endtask

    // Measures a timed phase; en_sel 1 expects sys_en, 2 expects acc_en, 0 neither.
    task automatic count_phase(input string tag, input logic [3:0] exp_st, input int exp_len,
                               input int en_sel, input bit inject);
        int n     = 0;
        int sys_n = 0;
        int acc_n = 0;
        int err_n = 0;
        check({tag, ".entry"}, state, exp_st);
        while (state == exp_st && n < 200) begin
            if (sys_en)  sys_n++;
            if (acc_en)  acc_n++;
            if (cfg_err) err_n++;
            if (inject && n == 2) begin
                start      = 1'b1;
                rc         = 2'b11;
                axi_finish = 1'b1;
            end
            if (inject && n == 4) begin
                start = 1'b1;
                rc    = 2'b01;
            end
            n++;
            @(posedge clk);
            #1;
            start      = 1'b0;
            axi_finish = 1'b0;
            @(negedge clk);
        end
        check({tag, ".len"},     n,     exp_len);
        check({tag, ".sys_en"},  sys_n, (en_sel == 1) ? exp_len : 0);
        check({tag, ".acc_en"},  acc_n, (en_sel == 2) ? exp_len : 0);
        check({tag, ".cfg_err"}, err_n, 0);
    endtask

    task automatic run_tile(input string tag, input logic [1:0] dt, input logic [1:0] shape,
                            input int st_time, input int wb_time,
                            input logic [31:0] a_bits, input logic [7:0] a_bsize, input logic [15:0] a_bnum,
                            input logic [31:0] b_bits, input logic [7:0] b_bsize, input logic [15:0] b_bnum,
                            input int exp_sys, input int exp_wait, input bit inject);
        dtype          = dt;
        rc             = shape;
        base           = {A_ADDR, B_ADDR, C_ADDR, D_ADDR};
        systolic_time  = 32'(st_time);
        writeback_time = 32'(wb_time);
        start          = 1'b1;
        @(posedge clk);
        #1;
        start          = 1'b0;
        dtype          = ~dt;
        base           = ~{A_ADDR, B_ADDR, C_ADDR, D_ADDR};
        systolic_time  = 32'd77;
        writeback_time = 32'd55;
        @(negedge clk);
        check({tag, ".busy"}, busy, 1'b1);
        serve_req({tag, ".C"}, S_READ_C, 3'b001, C_ADDR, 32'd8192, 8'd128, 16'd2, 1'b0);
        serve_req({tag, ".A"}, S_LOAD_A, 3'b100, A_ADDR, a_bits, a_bsize, a_bnum, 1'b0);
        serve_req({tag, ".B"}, S_LOAD_B, 3'b010, B_ADDR, b_bits, b_bsize, b_bnum, 1'b0);
        count_phase({tag, ".sys"}, S_SYSTOLIC, exp_sys, 1, inject);
        if (dt == T_INT8 || dt == T_INT4)
            count_phase({tag, ".acc"}, S_ACC, 2, 2, 1'b0);
        count_phase({tag, ".wait"}, S_WAIT, exp_wait, 0, 1'b0);
        serve_req({tag, ".D"}, S_WRITE_BACK, 3'b000, D_ADDR, 32'd8192, 8'd128, 16'd2, 1'b1);
        check({tag, ".fin_state"}, state, S_FINISH);
        check({tag, ".fin_done"},  done,  1'b1);
        check({tag, ".fin_busy"},  busy,  1'b1);
        @(negedge clk);
        check({tag, ".idle_state"}, state, S_IDLE);
        check({tag, ".idle_done"},  done,  1'b0);
        check({tag, ".idle_busy"},  busy,  1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1);
    end

    initial begin
        int valid_n;
        int err_n;
        rst            = 1'b1;
        start          = 1'b0;
        dtype          = T_FP32;
        rc             = 2'b00;
        base           = '0;
        systolic_time  = '0;
        writeback_time = '0;
        axi_finish     = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst.state",   state,          S_IDLE);
        check("rst.axi_lo",  axi_out[63:0],  64'd0);
        check("rst.axi_hi",  axi_out[92:64], 64'd0);
        check("rst.sys_en",  sys_en,  1'b0);
        check("rst.acc_en",  acc_en,  1'b0);
        check("rst.busy",    busy,    1'b0);
        check("rst.done",    done,    1'b0);
        check("rst.cfg_err", cfg_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // axi_finish in IDLE is ignored
        axi_finish = 1'b1;
        @(posedge clk);
        #1 axi_finish = 1'b0;
        @(negedge clk);
        check("idle_fin.state", state,   S_IDLE);
        check("idle_fin.valid", o_valid, 1'b0);

        // FP32 rc01 with stray start / axi_finish pulses during SYSTOLIC
        run_tile("fp32", T_FP32, 2'b01, 10, 3,
                 32'd8192, 8'd128, 16'd2, 32'd8192, 8'd128, 16'd2, 10, 3, 1'b1);

        // INT4 rc10: small bursts plus the accumulate phase
        run_tile("int4", T_INT4, 2'b10, 4, 2,
                 32'd512, 8'd16, 16'd1, 32'd2048, 8'd64, 16'd1, 4, 2, 1'b0);

        // Illegal shape is rejected
        rc    = 2'b11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("rej.cfg_err", cfg_err, 1'b1);
        check("rej.state",   state,   S_IDLE);
        check("rej.busy",    busy,    1'b0);
        valid_n = 0;
        err_n   = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_valid) valid_n++;
            if (cfg_err) err_n++;
        end
        check("rej.valid_never", valid_n, 0);
        check("rej.pulse_once",  err_n,   0);

        // Zero phase lengths still take one cycle; FP16 rc00
        run_tile("zero", T_FP16, 2'b00, 0, 0,
                 32'd8192, 8'd128, 16'd2, 32'd2048, 8'd64, 16'd1, 1, 1, 1'b0);

        // Reset in the middle of LOAD_B with request_valid high
        dtype          = T_FP32;
        rc             = 2'b00;
        base           = {A_ADDR, B_ADDR, C_ADDR, D_ADDR};
        systolic_time  = 32'd6;
        writeback_time = 32'd2;
        start          = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        serve_req("abort.C", S_READ_C, 3'b001, C_ADDR, 32'd8192,  8'd128, 16'd2, 1'b0);
        serve_req("abort.A", S_LOAD_A, 3'b100, A_ADDR, 32'd16384, 8'd128, 16'd4, 1'b0);
        check("abort.B_state", state, S_LOAD_B);
        check("abort.B_bits",  o_bits, 32'd4096);
        @(negedge clk);
        check("abort.B_valid", o_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort.state",   state,          S_IDLE);
        check("abort.axi_lo",  axi_out[63:0],  64'd0);
        check("abort.axi_hi",  axi_out[92:64], 64'd0);
        check("abort.busy",    busy,    1'b0);
        check("abort.sys_en",  sys_en,  1'b0);
        check("abort.done",    done,    1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort.idle_done", done, 1'b0);

        // A full tile after the abort: INT8 rc01
        run_tile("int8", T_INT8, 2'b01, 5, 2,
                 32'd2048, 8'd64, 16'd1, 32'd2048, 8'd64, 16'd1, 5, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
